// File: rtl/hazard_fwd_ctrl_if.sv
// Interface bundling the pipeline-facing signals of hazard_fwd_ctrl.
// Timing contract (no valid/ready pair on this block): every input is a level
// that is valid for the whole cycle. Every output is either combinational from the
// current inputs and the registered scoreboard state, or is itself a register.
// The pipeline registers consume the outputs on the next rising clk edge.
// master = pipeline side, slave = hazard_fwd_ctrl.
interface hazard_fwd_ctrl_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2
) ();
    logic [NUM_SRC*REG_AW-1:0] rs_id;
    logic [NUM_SRC*REG_AW-1:0] rs_ex;
    logic [REG_AW-1:0]         rd_ex;
    logic [REG_AW-1:0]         rd_mem;
    logic [REG_AW-1:0]         rd_wb;
    logic                      reg_wb_ex;
    logic                      reg_wb_mem;
    logic                      reg_wb_wb;
    logic                      is_load_ex;
    logic                      is_load_mem;
    logic                      mc_op_id;
    logic                      mc_start;
    logic                      mc_done;
    logic                      branch_taken;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic                      stall_pc_id;
    logic                      flush_id;
    logic                      bubble_ex;
    logic                      mc_pending;
    logic                      mc_err;
    logic [31:0]               stall_cnt;
    logic [31:0]               flush_cnt;

    modport master (
        output rs_id, rs_ex, rd_ex, rd_mem, rd_wb,
        output reg_wb_ex, reg_wb_mem, reg_wb_wb, is_load_ex, is_load_mem,
        output mc_op_id, mc_start, mc_done, branch_taken,
        input  fwd_sel, stall_pc_id, flush_id, bubble_ex,
        input  mc_pending, mc_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_id, rs_ex, rd_ex, rd_mem, rd_wb,
        input  reg_wb_ex, reg_wb_mem, reg_wb_wb, is_load_ex, is_load_mem,
        input  mc_op_id, mc_start, mc_done, branch_taken,
        output fwd_sel, stall_pc_id, flush_id, bubble_ex,
        output mc_pending, mc_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard / forwarding controller for the 5-stage RV pipeline.
// Produces per-source EX forwarding selects, the load-use stall, the taken-branch
// flush, and tracks one multi-cycle (MUL/DIV) op in flight with a timeout.
// Optional feature macro: HAZARD_STATS_EN adds saturating stall/flush cycle
// counters. When it is undefined, stall_cnt and flush_cnt are tied to zero.
// o_dbg_state exposes the scoreboard FSM state (1 = PEND).
module hazard_fwd_ctrl #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int MC_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_fwd_ctrl_if.slave  bus,
    output logic              o_dbg_state
);
    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MC_TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } sb_state_t;

    sb_state_t         r_state;
    sb_state_t         w_state_nxt;
    logic [REG_AW-1:0] r_mc_rd;
    logic [REG_AW-1:0] w_mc_rd_nxt;
    logic [TW-1:0]     r_timer;
    logic [TW-1:0]     w_timer_nxt;
    logic              r_mc_err;
    logic              w_mc_err_nxt;

    logic [NUM_SRC*2-1:0] w_fwd_sel;
    logic                 w_lu_hit;
    logic                 w_sb_hit;
    logic                 w_lu;
    logic                 w_sb;
    logic                 w_stall;
    logic                 w_flush;
    logic                 w_bubble;

    // Scoreboard state register: the async reset drops any pending op and the error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mc_rd  <= '0;
            r_timer  <= '0;
            r_mc_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_rd  <= w_mc_rd_nxt;
            r_timer  <= w_timer_nxt;
            r_mc_err <= w_mc_err_nxt;
        end
    end

    // Scoreboard next state. A done that arrives together with a new start keeps the unit
    // busy with the new op. A start while busy without done is not a legal
    // second op and is ignored.
    always_comb begin
        w_state_nxt  = r_state;
        w_mc_rd_nxt  = r_mc_rd;
        w_timer_nxt  = r_timer;
        w_mc_err_nxt = r_mc_err;
        case (r_state)
            ST_IDLE: begin
                if (bus.mc_start) begin
                    w_state_nxt = ST_PEND;
                    w_mc_rd_nxt = bus.rd_ex;
                    w_timer_nxt = '0;
                end
            end
            ST_PEND: begin
                if (bus.mc_done) begin
                    w_timer_nxt = '0;
                    if (bus.mc_start) begin
                        w_mc_rd_nxt = bus.rd_ex;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_timer == TIMER_LAST) begin
                    w_state_nxt  = ST_IDLE;
                    w_timer_nxt  = '0;
                    w_mc_err_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Per-source forwarding selects and the RAW matches against the EX destination and the scoreboard.
    // MEM has priority over WB. A load in MEM has no data yet, so it never forwards.
    always_comb begin
        w_fwd_sel = '0;
        w_lu_hit  = 1'b0;
        w_sb_hit  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.reg_wb_mem && !bus.is_load_mem && (bus.rd_mem != '0) &&
                (bus.rs_ex[i*REG_AW +: REG_AW] == bus.rd_mem)) begin
                w_fwd_sel[i*2 +: 2] = 2'b01;
            end else if (bus.reg_wb_wb && (bus.rd_wb != '0) &&
                         (bus.rs_ex[i*REG_AW +: REG_AW] == bus.rd_wb)) begin
                w_fwd_sel[i*2 +: 2] = 2'b10;
            end
            if ((bus.rd_ex != '0) && (bus.rs_id[i*REG_AW +: REG_AW] == bus.rd_ex)) begin
                w_lu_hit = 1'b1;
            end
            if ((r_mc_rd != '0) && (bus.rs_id[i*REG_AW +: REG_AW] == r_mc_rd)) begin
                w_sb_hit = 1'b1;
            end
        end
    end

    // Stall / flush / bubble: a taken branch makes the ID instruction wrong-path,
    // so it wins over any stall. It does not touch the scoreboard, because the MC op is older.
    always_comb begin
        w_lu     = bus.is_load_ex && bus.reg_wb_ex && w_lu_hit;
        w_sb     = (r_state == ST_PEND) && (w_sb_hit || bus.mc_op_id);
        w_stall  = (w_lu || w_sb) && !bus.branch_taken;
        w_flush  = bus.branch_taken;
        w_bubble = w_lu || w_sb || bus.branch_taken;
    end

    // All outputs are held at zero while reset is asserted.
    assign bus.fwd_sel     = rst_n ? w_fwd_sel : '0;
    assign bus.stall_pc_id = rst_n && w_stall;
    assign bus.flush_id    = rst_n && w_flush;
    assign bus.bubble_ex   = rst_n && w_bubble;
    assign bus.mc_pending  = (r_state == ST_PEND);
    assign bus.mc_err      = r_mc_err;
    assign o_dbg_state     = (r_state == ST_PEND);

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating perf counters for cycles spent stalling and flushing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed scenarios plus randomized cycles checked
// against a behavioural model. The model tracks the multi-cycle op as "edge on
// which it started" and measures age in clock edges.
module tb_hazard_fwd_ctrl;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int TMO = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NS*AW-1:0] t_rs_id, t_rs_ex;
  logic [AW-1:0] t_rd_ex, t_rd_mem, t_rd_wb;
  logic t_reg_wb_ex, t_reg_wb_mem, t_reg_wb_wb, t_is_load_ex, t_is_load_mem;
  logic t_mc_op_id, t_mc_start, t_mc_done, t_branch;
  logic dbg_state;

  hazard_fwd_ctrl_if #(.REG_AW(AW), .NUM_SRC(NS)) bus ();

  assign bus.rs_id = t_rs_id;
  assign bus.rs_ex = t_rs_ex;
  assign bus.rd_ex = t_rd_ex;
  assign bus.rd_mem = t_rd_mem;
  assign bus.rd_wb = t_rd_wb;
  assign bus.reg_wb_ex = t_reg_wb_ex;
  assign bus.reg_wb_mem = t_reg_wb_mem;
  assign bus.reg_wb_wb = t_reg_wb_wb;
  assign bus.is_load_ex = t_is_load_ex;
  assign bus.is_load_mem = t_is_load_mem;
  assign bus.mc_op_id = t_mc_op_id;
  assign bus.mc_start = t_mc_start;
  assign bus.mc_done = t_mc_done;
  assign bus.branch_taken = t_branch;

  hazard_fwd_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .MC_TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fails = 0;

  // ---------------- reference model ----------------
  bit m_pending;
  bit m_err;
  logic [AW-1:0] m_rd;
  longint m_start_edge;
  longint edge_cnt;
  longint m_stall_cnt;
  longint m_flush_cnt;

  // expected {fwd_sel[3:0], stall_pc_id, flush_id, bubble_ex, mc_pending, mc_err}
  function automatic logic [8:0] model_outs();
    logic [3:0] fwd;
    logic [AW-1:0] s_ex, s_id;
    logic lu, raw, sb, haz;
    fwd = '0;
    lu = 1'b0;
    raw = 1'b0;
    for (int i = 0; i < NS; i++) begin
      s_ex = t_rs_ex[i*AW +: AW];
      s_id = t_rs_id[i*AW +: AW];
      if (s_ex != 0 && t_reg_wb_mem && !t_is_load_mem && s_ex == t_rd_mem) fwd[i*2 +: 2] = 2'b01;
      else if (s_ex != 0 && t_reg_wb_wb && s_ex == t_rd_wb) fwd[i*2 +: 2] = 2'b10;
      if (s_id != 0 && s_id == t_rd_ex) lu = 1'b1;
      if (s_id != 0 && s_id == m_rd) raw = 1'b1;
    end
    lu = lu && t_is_load_ex && t_reg_wb_ex;
    sb = m_pending && (raw || t_mc_op_id);
    haz = lu || sb;
    return {fwd, haz && !t_branch, t_branch, haz || t_branch, m_pending, m_err};
  endfunction

  function automatic logic [31:0] exp_stall_cnt();
`ifdef HAZARD_STATS_EN
    return m_stall_cnt[31:0];
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_flush_cnt();
`ifdef HAZARD_STATS_EN
    return m_flush_cnt[31:0];
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [8:0] dut_outs();
    return {bus.fwd_sel, bus.stall_pc_id, bus.flush_id, bus.bubble_ex, bus.mc_pending, bus.mc_err};
  endfunction

  task automatic model_reset();
    m_pending = 0;
    m_err = 0;
    m_rd = '0;
    m_start_edge = 0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    t_rs_id = '0; t_rs_ex = '0;
    t_rd_ex = '0; t_rd_mem = '0; t_rd_wb = '0;
    t_reg_wb_ex = 0; t_reg_wb_mem = 0; t_reg_wb_wb = 0;
    t_is_load_ex = 0; t_is_load_mem = 0;
    t_mc_op_id = 0; t_mc_start = 0; t_mc_done = 0; t_branch = 0;
  endtask

  // advance one clock edge and move the model across it
  task automatic tick();
    logic [8:0] e;
    e = model_outs();
    if (e[4] && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
    if (e[3] && m_flush_cnt < 64'hFFFF_FFFF) m_flush_cnt++;
    @(posedge clk);
    edge_cnt++;
    if (m_pending) begin
      if (t_mc_done) begin
        if (t_mc_start) begin
          m_rd = t_rd_ex;
          m_start_edge = edge_cnt;
        end else begin
          m_pending = 0;
        end
      end else if (edge_cnt - m_start_edge == TMO) begin
        m_pending = 0;
        m_err = 1;
      end
    end else if (t_mc_start) begin
      m_pending = 1;
      m_rd = t_rd_ex;
      m_start_edge = edge_cnt;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    t_branch = 1; t_is_load_ex = 1; t_reg_wb_ex = 1; t_rd_ex = 5'd3; t_rs_id = {5'd3, 5'd3};
    t_reg_wb_mem = 1; t_rd_mem = 5'd4; t_rs_ex = {5'd4, 5'd4};
    rst_n = 0;
    @(negedge clk);
    n_checks++;
    if (dut_outs() !== 9'd0) begin
      n_fails++; $display("FAIL reset_outs got=%b exp=%b", dut_outs(), 9'd0);
    end
    n_checks++;
    if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0 || dbg_state !== 1'b0) begin
      n_fails++; $display("FAIL reset_cnt got stall=%0d flush=%0d dbg=%b exp 0/0/0",
                          bus.stall_cnt, bus.flush_cnt, dbg_state);
    end
    clear_inputs();
    #2 rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_forwarding();
    clear_inputs();
    t_reg_wb_mem = 1; t_rd_mem = 5'd5; t_rs_ex = {5'd0, 5'd5};
    @(negedge clk);
    n_checks++;
    if (bus.fwd_sel[1:0] !== 2'b01) begin
      n_fails++; $display("FAIL fwd_mem got=%b exp=01", bus.fwd_sel[1:0]);
    end
    tick();
    t_reg_wb_wb = 1; t_rd_wb = 5'd5;
    @(negedge clk);
    n_checks++;
    if (bus.fwd_sel !== 4'b0001) begin
      n_fails++; $display("FAIL fwd_mem_over_wb got=%b exp=0001", bus.fwd_sel);
    end
    tick();
    clear_inputs();
    t_reg_wb_mem = 1; t_rd_mem = 5'd0; t_rs_ex = {5'd0, 5'd0};
    @(negedge clk);
    n_checks++;
    if (bus.fwd_sel !== 4'b0000) begin
      n_fails++; $display("FAIL fwd_x0 got=%b exp=0000", bus.fwd_sel);
    end
    tick();
    clear_inputs();
    t_reg_wb_mem = 1; t_is_load_mem = 1; t_rd_mem = 5'd7; t_rs_ex = {5'd7, 5'd0};
    @(negedge clk);
    n_checks++;
    if (bus.fwd_sel[3:2] !== 2'b00) begin
      n_fails++; $display("FAIL fwd_load_mem got=%b exp=00", bus.fwd_sel[3:2]);
    end
    tick();
    t_reg_wb_wb = 1; t_rd_wb = 5'd7;
    @(negedge clk);
    n_checks++;
    if (bus.fwd_sel !== 4'b1000) begin
      n_fails++; $display("FAIL fwd_wb_src1 got=%b exp=1000", bus.fwd_sel);
    end
    tick();
    for (int c = 0; c < 40; c++) begin
      clear_inputs();
      t_rs_ex = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      t_rd_mem = 5'($urandom_range(0, 3)); t_rd_wb = 5'($urandom_range(0, 3));
      t_reg_wb_mem = 1'($urandom); t_reg_wb_wb = 1'($urandom); t_is_load_mem = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (bus.fwd_sel !== model_outs()[8:5]) begin
        n_fails++; $display("FAIL fwd_rand got=%b exp=%b", bus.fwd_sel, model_outs()[8:5]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    t_is_load_ex = 1; t_reg_wb_ex = 1; t_rd_ex = 5'd3; t_rs_id = {5'd3, 5'd1};
    @(negedge clk);
    n_checks++;
    if ({bus.stall_pc_id, bus.bubble_ex, bus.flush_id} !== 3'b110) begin
      n_fails++; $display("FAIL load_use_stall got=%b exp=110", {bus.stall_pc_id, bus.bubble_ex, bus.flush_id});
    end
    tick();
    t_is_load_ex = 0; t_reg_wb_ex = 0; t_rd_ex = 5'd0;
    t_is_load_mem = 1; t_reg_wb_mem = 1; t_rd_mem = 5'd3;
    @(negedge clk);
    n_checks++;
    if ({bus.stall_pc_id, bus.bubble_ex} !== 2'b00) begin
      n_fails++; $display("FAIL load_use_release got=%b exp=00", {bus.stall_pc_id, bus.bubble_ex});
    end
    tick();
    clear_inputs();
    t_reg_wb_ex = 1; t_rd_ex = 5'd3; t_rs_id = {5'd3, 5'd3};
    @(negedge clk);
    n_checks++;
    if (bus.stall_pc_id !== 1'b0) begin
      n_fails++; $display("FAIL alu_no_stall got=%b exp=0", bus.stall_pc_id);
    end
    tick();
    t_is_load_ex = 1; t_rd_ex = 5'd0; t_rs_id = {5'd0, 5'd0};
    @(negedge clk);
    n_checks++;
    if (bus.stall_pc_id !== 1'b0) begin
      n_fails++; $display("FAIL load_x0_no_stall got=%b exp=0", bus.stall_pc_id);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_mc_scoreboard();
    clear_inputs();
    t_mc_start = 1; t_rd_ex = 5'd9;
    @(negedge clk);
    n_checks++;
    if ({bus.mc_pending, bus.stall_pc_id} !== 2'b00) begin
      n_fails++; $display("FAIL mc_launch got=%b exp=00", {bus.mc_pending, bus.stall_pc_id});
    end
    tick();
    clear_inputs();
    t_rs_id = {5'd2, 5'd9};
    for (int c = 1; c <= 10; c++) begin
      t_mc_done = (c == 10);
      @(negedge clk);
      n_checks++;
      if ({bus.mc_pending, bus.stall_pc_id, bus.bubble_ex} !== 3'b111) begin
        n_fails++; $display("FAIL mc_raw_stall cyc=%0d got=%b exp=111", c,
                            {bus.mc_pending, bus.stall_pc_id, bus.bubble_ex});
      end
      tick();
    end
    t_mc_done = 0;
    @(negedge clk);
    n_checks++;
    if ({bus.mc_pending, bus.stall_pc_id} !== 2'b00) begin
      n_fails++; $display("FAIL mc_release got=%b exp=00", {bus.mc_pending, bus.stall_pc_id});
    end
    // done while idle is ignored
    t_mc_done = 1;
    tick();
    t_mc_done = 0;
    // x0 destination: pending but no RAW stall, mc_op_id still stalls
    t_mc_start = 1; t_rd_ex = 5'd0;
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if ({bus.mc_pending, bus.stall_pc_id} !== 2'b10) begin
      n_fails++; $display("FAIL mc_x0 got=%b exp=10", {bus.mc_pending, bus.stall_pc_id});
    end
    tick();
    t_mc_op_id = 1;
    @(negedge clk);
    n_checks++;
    if (bus.stall_pc_id !== 1'b1) begin
      n_fails++; $display("FAIL mc_op_id_stall got=%b exp=1", bus.stall_pc_id);
    end
    // back-to-back: done with a new start relatches the destination
    t_mc_op_id = 0; t_mc_done = 1; t_mc_start = 1; t_rd_ex = 5'd6;
    tick();
    clear_inputs();
    t_rs_id = {5'd0, 5'd0};
    @(negedge clk);
    n_checks++;
    if ({bus.mc_pending, bus.stall_pc_id} !== 2'b10) begin
      n_fails++; $display("FAIL mc_b2b_pending got=%b exp=10", {bus.mc_pending, bus.stall_pc_id});
    end
    tick();
    t_rs_id = {5'd6, 5'd0};
    @(negedge clk);
    n_checks++;
    if (bus.stall_pc_id !== 1'b1) begin
      n_fails++; $display("FAIL mc_b2b_relatch got=%b exp=1", bus.stall_pc_id);
    end
    t_mc_done = 1;
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (dut_outs() !== model_outs()) begin
      n_fails++; $display("FAIL mc_end_model got=%b exp=%b", dut_outs(), model_outs());
    end
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    clear_inputs();
    t_mc_start = 1; t_rd_ex = 5'd12;
    tick();
    clear_inputs();
    cnt = 0;
    while (cnt < 200) begin
      @(negedge clk);
      if (bus.mc_pending !== 1'b1) break;
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt != TMO) begin
      n_fails++; $display("FAIL timeout_len got=%0d exp=%0d", cnt, TMO);
    end
    n_checks++;
    if (dut_outs() !== model_outs() || bus.mc_err !== 1'b1) begin
      n_fails++; $display("FAIL timeout_err got=%b exp=%b", dut_outs(), model_outs());
    end
    for (int c = 0; c < 3; c++) tick();
    t_mc_start = 1; t_rd_ex = 5'd12;
    tick();
    t_mc_start = 0;
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.mc_pending, bus.mc_err} !== 2'b11) begin
      n_fails++; $display("FAIL err_sticky got=%b exp=11", {bus.mc_pending, bus.mc_err});
    end
    // asynchronous reset in the middle of a pending op
    rst_n = 0;
    #1;
    n_checks++;
    if ({bus.mc_pending, bus.mc_err, dbg_state} !== 3'b000) begin
      n_fails++; $display("FAIL reset_mid_pend got=%b exp=000", {bus.mc_pending, bus.mc_err, dbg_state});
    end
    #2 rst_n = 1;
    model_reset();
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    t_mc_start = 1; t_rd_ex = 5'd9;
    tick();
    clear_inputs();
    t_branch = 1; t_is_load_ex = 1; t_reg_wb_ex = 1; t_rd_ex = 5'd3; t_rs_id = {5'd9, 5'd3};
    @(negedge clk);
    n_checks++;
    if ({bus.stall_pc_id, bus.flush_id, bus.bubble_ex, bus.mc_pending} !== 4'b0111) begin
      n_fails++; $display("FAIL branch_prio got=%b exp=0111",
                          {bus.stall_pc_id, bus.flush_id, bus.bubble_ex, bus.mc_pending});
    end
    tick();
    t_branch = 0;
    @(negedge clk);
    n_checks++;
    if (bus.mc_pending !== 1'b1 || bus.stall_pc_id !== 1'b1) begin
      n_fails++; $display("FAIL branch_keeps_sb got=%b exp=11", {bus.mc_pending, bus.stall_pc_id});
    end
    n_checks++;
    if (bus.flush_cnt !== exp_flush_cnt() || bus.stall_cnt !== exp_stall_cnt()) begin
      n_fails++; $display("FAIL branch_cnt got=%0d/%0d exp=%0d/%0d", bus.stall_cnt, bus.flush_cnt,
                          exp_stall_cnt(), exp_flush_cnt());
    end
    t_mc_done = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      t_rs_id = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      t_rs_ex = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      t_rd_ex = 5'($urandom_range(0, 7)); t_rd_mem = 5'($urandom_range(0, 7));
      t_rd_wb = 5'($urandom_range(0, 7));
      t_reg_wb_ex = 1'($urandom); t_reg_wb_mem = 1'($urandom); t_reg_wb_wb = 1'($urandom);
      t_is_load_ex = 1'($urandom); t_is_load_mem = 1'($urandom);
      t_mc_op_id = ($urandom_range(0, 3) == 0);
      t_mc_start = ($urandom_range(0, 5) == 0);
      t_mc_done = ($urandom_range(0, 7) == 0);
      t_branch = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      n_checks++;
      if ({dut_outs(), dbg_state} !== {model_outs(), m_pending}) begin
        n_fails++; $display("FAIL rand_outs cyc=%0d got=%b exp=%b", c, {dut_outs(), dbg_state},
                            {model_outs(), m_pending});
      end
      n_checks++;
      if (bus.stall_cnt !== exp_stall_cnt() || bus.flush_cnt !== exp_flush_cnt()) begin
        n_fails++; $display("FAIL rand_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", c, bus.stall_cnt,
                            bus.flush_cnt, exp_stall_cnt(), exp_flush_cnt());
      end
      tick();
    end
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    edge_cnt = 0;
    model_reset();
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_mc_scoreboard();
    test_timeout();
    test_branch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
